// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/refresh generation, flush sequencing and an optional
// iterative-divide tracker (enabled by defining PIPE_CTRL_DIV_EN).
module pipe_ctrl (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  input  logic id_load_use,
  input  logic ex_div_start,
  input  logic d_busy,
  input  logic mem_exc,
  input  logic mem_eret,
  output logic pc_stall,
  output logic if_id_stall,
  output logic id_ex_stall,
  output logic ex_mem_stall,
  output logic mem_wb_stall,
  output logic if_id_refresh,
  output logic id_ex_refresh,
  output logic ex_mem_refresh,
  output logic mem_wb_refresh,
  output logic div_busy,
  output logic div_done,
  output logic flush_pending
);

  localparam int unsigned N_STAGE = 5;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DIV_LAST = 31;

  logic                    flush_req;
  logic                    flush_go;
  logic                    flush_defer;
  logic                    mem_busy;
  logic                    div_busy_c;
  logic                    div_done_c;
  logic                    lvl_valid;
  logic [LVL_W-1:0]        lvl;
  logic [N_STAGE-1:0]      stall;
  logic [N_STAGE-1:1]      refresh;

  // A flush can only retire once neither memory port is mid-access; otherwise it is held.
  assign mem_busy    = i_busy | d_busy;
  assign flush_req   = mem_exc | mem_eret | flush_pending;
  assign flush_go    = flush_req & ~mem_busy;
  assign flush_defer = flush_req & mem_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= flush_defer;
    end
  end

`ifdef PIPE_CTRL_DIV_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } div_state_t;

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             div_start;
  logic             cnt_zero;

  assign div_start = (state == S_IDLE) & ex_div_start & ~flush_req;
  assign cnt_zero  = (cnt == '0);

  // Divider sequencing: start loads the counter, an executed flush aborts without div_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (flush_go) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            state <= S_DIV;
            cnt   <= CNT_W'(DIV_LAST);
          end
        end
        S_DIV: begin
          if (cnt_zero) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign div_busy_c = ~reset & (div_start | ((state == S_DIV) & ~cnt_zero));
  assign div_done_c = ~reset & (state == S_DIV) & cnt_zero & ~flush_go;
`else
  logic unused_ex_div_start;

  assign unused_ex_div_start = ex_div_start;
  assign div_busy_c          = 1'b0;
  assign div_done_c          = 1'b0;
`endif

  // Deepest active stall source sets the stall level.
  always_comb begin
    lvl_valid = 1'b0;
    lvl       = '0;
    if (d_busy) begin
      lvl_valid = 1'b1;
      lvl       = LVL_W'(3);
    end else if (div_busy_c) begin
      lvl_valid = 1'b1;
      lvl       = LVL_W'(2);
    end else if (id_load_use) begin
      lvl_valid = 1'b1;
      lvl       = LVL_W'(1);
    end else if (i_busy) begin
      lvl_valid = 1'b1;
      lvl       = LVL_W'(0);
    end
  end

  // Flush outranks every stall source; a deferred flush freezes the whole pipe.
  always_comb begin
    stall   = '0;
    refresh = '0;
    if (reset || flush_go) begin
      refresh = '1;
    end else if (flush_defer) begin
      stall = '1;
    end else if (lvl_valid) begin
      for (int unsigned s = 0; s < N_STAGE; s++) begin
        stall[s] = (LVL_W'(s) <= lvl);
      end
      for (int unsigned s = 1; s < N_STAGE; s++) begin
        refresh[s] = (LVL_W'(s) == (lvl + LVL_W'(1)));
      end
    end
  end

  assign pc_stall       = stall[0];
  assign if_id_stall    = stall[1];
  assign id_ex_stall    = stall[2];
  assign ex_mem_stall   = stall[3];
  assign mem_wb_stall   = stall[4];
  assign if_id_refresh  = refresh[1];
  assign id_ex_refresh  = refresh[2];
  assign ex_mem_refresh = refresh[3];
  assign mem_wb_refresh = refresh[4];
  assign div_busy       = div_busy_c;
  assign div_done       = div_done_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes model-predicted outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_BUSY_CYCLES = 32;

  logic clk = 1'b0;
  logic reset, i_busy, id_load_use, ex_div_start, d_busy, mem_exc, mem_eret;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic div_busy, div_done, flush_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  // Reference model state: divider tracked as elapsed cycles since the start cycle.
  bit m_fp, m_active;
  int m_elapsed;
  bit n_fp, n_active;
  int n_elapsed;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .id_load_use(id_load_use),
    .ex_div_start(ex_div_start), .d_busy(d_busy), .mem_exc(mem_exc), .mem_eret(mem_eret),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
    .ex_mem_refresh(ex_mem_refresh), .mem_wb_refresh(mem_wb_refresh),
    .div_busy(div_busy), .div_done(div_done), .flush_pending(flush_pending)
  );

  task automatic model_eval(input string tag);
    bit freq, go, defer, busy, done;
    bit st[5];
    bit rf[5];
    int k;
    for (int s = 0; s < 5; s++) begin st[s] = 0; rf[s] = 0; end
    busy = 0; done = 0;
    if (reset) begin
      m_fp = 0; m_active = 0; m_elapsed = 0;
      n_fp = 0; n_active = 0; n_elapsed = 0;
      for (int s = 1; s < 5; s++) rf[s] = 1;
    end else begin
      freq  = mem_exc || mem_eret || m_fp;
      go    = freq && !i_busy && !d_busy;
      defer = freq && (i_busy || d_busy);
      n_active = m_active; n_elapsed = m_elapsed;
      if (DIV_EN) begin
        if (!m_active) begin
          if (ex_div_start && !freq) begin
            busy = 1; n_active = 1; n_elapsed = 1;
          end
        end else begin
          busy = (m_elapsed < DIV_BUSY_CYCLES);
          done = (m_elapsed == DIV_BUSY_CYCLES) && !go;
          if (go || m_elapsed == DIV_BUSY_CYCLES) begin
            n_active = 0; n_elapsed = 0;
          end else begin
            n_elapsed = m_elapsed + 1;
          end
        end
      end
      k = -1;
      if (i_busy)      k = 0;
      if (id_load_use) k = 1;
      if (busy)        k = 2;
      if (d_busy)      k = 3;
      if (go) begin
        for (int s = 1; s < 5; s++) rf[s] = 1;
      end else if (defer) begin
        for (int s = 0; s < 5; s++) st[s] = 1;
      end else if (k >= 0) begin
        for (int s = 0; s < 5; s++) st[s] = (s <= k);
        rf[k + 1] = 1;
      end
      n_fp = defer;
    end
    exp_q.push_back({st[0], st[1], st[2], st[3], st[4], rf[1], rf[2], rf[3], rf[4],
                     busy, done, m_fp});
    tag_q.push_back(tag);
  endtask

  // One cycle: registers update at the edge, then new inputs go in mid-cycle.
  task automatic drive(input string tag, input logic r, input logic ib, input logic lu,
                       input logic ds, input logic db, input logic me, input logic mr);
    @(posedge clk);
    #1;
    m_fp = n_fp; m_active = n_active; m_elapsed = n_elapsed;
    reset = r; i_busy = ib; id_load_use = lu; ex_div_start = ds;
    d_busy = db; mem_exc = me; mem_eret = mr;
    model_eval(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
  initial begin : monitor
    logic [11:0] act, e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh,
               div_busy, div_done, flush_pending};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got stall=%b ref=%b busy/done/fp=%b, want stall=%b ref=%b busy/done/fp=%b",
                   t, $time, act[11:7], act[6:3], act[2:0], e[11:7], e[6:3], e[2:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1; i_busy = 0; id_load_use = 0; ex_div_start = 0;
    d_busy = 0; mem_exc = 0; mem_eret = 0;
    m_fp = 0; m_active = 0; m_elapsed = 0; n_fp = 0; n_active = 0; n_elapsed = 0;

    drive("reset_hold", 1, 0, 0, 0, 0, 0, 0);
    drive("reset_hold_inputs", 1, 1, 1, 1, 1, 1, 0);
    idle("idle", 2);

    drive("load_use", 0, 0, 1, 0, 0, 0, 0);
    idle("after_load_use", 1);
    drive("i_busy_only", 0, 1, 0, 0, 0, 0, 0);
    drive("d_busy_only", 0, 0, 0, 0, 1, 0, 0);
    drive("overlap_dbusy_lu", 0, 0, 1, 0, 1, 0, 0);
    drive("overlap_ibusy_lu", 0, 1, 1, 0, 0, 0, 0);
    idle("idle", 1);

    drive("flush_defer", 0, 1, 0, 0, 0, 1, 0);
    drive("flush_wait", 0, 1, 0, 0, 0, 0, 0);
    drive("flush_done", 0, 0, 0, 0, 0, 0, 0);
    idle("after_flush", 1);
    drive("flush_defer_dbusy", 0, 0, 0, 0, 1, 0, 1);
    drive("flush_done_prio", 0, 0, 1, 0, 0, 0, 0);
    drive("flush_over_lu", 0, 0, 1, 1, 0, 1, 0);
    idle("idle", 1);

    drive("div_start", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 34; i++)
      drive("div_run", 0, 0, 0, (i < 32 && i % 5 == 0), 0, 0, 0);
    idle("idle", 1);

    drive("div2_start", 0, 0, 0, 1, 0, 0, 0);
    idle("div2_run", 21);
    drive("div2_eret_cnt10", 0, 0, 0, 0, 0, 0, 1);
    idle("div2_after_abort", 15);

    drive("div3_start", 0, 0, 0, 1, 0, 0, 0);
    idle("div3_run", 24);
    drive("div3_defer", 0, 1, 0, 0, 0, 1, 0);
    drive("div3_pending", 0, 1, 0, 0, 0, 0, 0);
    drive("div3_reset_cnt5", 1, 1, 0, 0, 0, 0, 0);
    idle("div3_after_reset", 40);

    for (int i = 0; i < 2000; i++) begin
      drive("random",
            ($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 3));
    end
    idle("tail", 3);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have i_busy, input, 1, instruction fetch not complete this cycle.
REQ-004 SHALL have id_load_use, input, 1, load-use hazard detected in ID.
REQ-005 SHALL have ex_div_start, input, 1, divide instruction present in EX.
REQ-006 SHALL have d_busy, input, 1, data access in MEM not complete this cycle.
REQ-007 SHALL have mem_exc and mem_eret, inputs, 1 each, exception or eret committed in MEM.
REQ-008 SHALL have pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_stall, outputs, 1 each, hold the named register.
REQ-009 SHALL have if_id_refresh, id_ex_refresh, ex_mem_refresh and mem_wb_refresh, outputs, 1 each, clear the named register to a bubble.
REQ-010 SHALL have div_busy, div_done and flush_pending, outputs, 1 each, status.

Function
REQ-011 SHALL drive all stall and refresh outputs combinationally from the current inputs and registered state, with zero-cycle latency.
REQ-012 SHALL define stage order as pc=0, if_id=1, id_ex=2, ex_mem=3, mem_wb=4.
REQ-013 SHALL set the stall level k for each source: i_busy to 0, id_load_use to 1, div_busy to 2, d_busy to 3.
REQ-014 SHALL, when one or more sources are active, take the deepest k, assert stall on every stage at or below k, assert refresh on stage k+1, and leave the remaining outputs at 0.
REQ-015 SHALL treat the flush request as mem_exc OR mem_eret OR the flush_pending register.
REQ-016 SHALL, on a flush request with i_busy=0 and d_busy=0, assert if_id_refresh, id_ex_refresh, ex_mem_refresh and mem_wb_refresh, with all stalls at 0.
REQ-017 SHALL, on that same flush cycle, clear flush_pending and abort the divider.
REQ-018 SHALL, on a flush request with i_busy=1 or d_busy=1, assert all five stalls, keep all refreshes at 0, and set flush_pending on the next edge.
REQ-019 SHALL give a flush request priority over every stall source of REQ-013.
REQ-020 SHALL implement the divider FSM as two states: IDLE and DIV, with a 5-bit down-counter cnt.
REQ-021 SHALL move from IDLE to DIV with cnt=31 when ex_div_start=1 and no flush request is active.
REQ-022 SHALL drive div_busy=1 in that IDLE start cycle.
REQ-023 SHALL, in DIV, decrement cnt every cycle regardless of d_busy or i_busy.
REQ-024 SHALL, in DIV, drive div_busy=1 while cnt!=0.
REQ-025 SHALL, in DIV with cnt==0, drive div_busy=0 and pulse div_done=1 for one cycle, then return to IDLE.
REQ-026 SHALL hold EX for exactly 33 cycles from the start cycle up to and including the div_done cycle.
REQ-027 SHALL ignore ex_div_start while in DIV.
REQ-028 SHALL abort the divider on a flush: next state IDLE, cnt=0, no div_done.
REQ-029 SHALL not wrap cnt below 0.

Reset
REQ-030 SHALL, on reset, force state=IDLE, cnt=0 and flush_pending=0 asynchronously.
REQ-031 SHALL, while reset is asserted, drive all stall outputs to 0, all refresh outputs to 1, and div_busy and div_done to 0.
REQ-032 SHALL, on reset mid-divide, discard the operation and not pulse div_done after release.

Configuration
REQ-033 SHALL include the divider FSM, div_busy and div_done when PIPE_CTRL_DIV_EN is defined.
REQ-034 SHALL, when PIPE_CTRL_DIV_EN is undefined, ignore ex_div_start, tie div_busy and div_done to 0, and omit the FSM and counter.

Verification
REQ-035 SHALL test load-use: id_load_use=1 for 1 cycle gives pc_stall=1, if_id_stall=1 and id_ex_refresh=1, with all other outputs 0.
REQ-036 SHALL test a divide: ex_div_start=1 at cycle 0 gives div_busy=1 for cycles 0-31, div_done=1 at cycle 32, and id_ex_stall=1 for cycles 0-31.
REQ-037 SHALL test overlapping stalls: d_busy=1 together with id_load_use=1 gives stalls on stages 0-3, mem_wb_refresh=1 and id_ex_refresh=0.
REQ-038 SHALL test a deferred flush: mem_exc=1 with i_busy=1 gives all stalls=1, and flush_pending=1 next cycle.
REQ-039 SHALL test flush completion: when i_busy drops after a deferred flush, all four refreshes=1 and flush_pending=0 on the next cycle.
REQ-040 SHALL test a flush mid-divide: mem_eret=1 at cnt=10 gives four refreshes, state IDLE next cycle, and div_done never asserted.
REQ-041 SHALL test async reset: reset asserted at cnt=5 mid-cycle immediately gives div_busy=0 and flush_pending=0, with no div_done after release.
